// File: rtl/memsys_pkg.sv
// Shared types and TLB layout constants for the memory subsystem arbiter.
package memsys_pkg;

  localparam int unsigned TLB_ENTRIES      = 8;
  localparam int unsigned TLB_ENTRY_W      = 44;
  localparam int unsigned TLB_W            = TLB_ENTRIES * TLB_ENTRY_W;
  localparam int unsigned TLB_VPN_LSB      = 24;
  localparam int unsigned TLB_VPN_W        = 20;
  localparam int unsigned TLB_PPN_LSB      = 4;
  localparam int unsigned TLB_PPN_W        = 20;
  localparam int unsigned TLB_VALID_BIT    = 3;
  localparam int unsigned TLB_PRESENT_BIT  = 2;
  localparam int unsigned TLB_WRITABLE_BIT = 1;
  localparam int unsigned TLB_PCD_BIT      = 0;

  // Encoding doubles as the fixed-priority rank (0 = highest).
  typedef enum logic [1:0] {
    PORT_E = 2'd0,
    PORT_W = 2'd1,
    PORT_R = 2'd2,
    PORT_I = 2'd3
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/memsys_tlb_lookup.sv
// Combinational 8-entry TLB lookup: virtual address -> physical address and fault.
module memsys_tlb_lookup
  import memsys_pkg::*;
(
  input  logic [TLB_W-1:0] tlb_contents,
  input  logic [31:0]      va,
  input  logic             is_write,
  output logic [31:0]      pa,
  output logic             fault
);

  logic [TLB_ENTRY_W-1:0] entry;
  logic [TLB_ENTRY_W-1:0] cur;
  logic                   hit;
  int unsigned            idx;

  // Scan from the highest index down so the lowest matching entry is kept last.
  always_comb begin
    entry = '0;
    cur   = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int unsigned n = 0; n < TLB_ENTRIES; n++) begin
      idx = TLB_ENTRIES - 1 - n;
      cur = tlb_contents[(TLB_ENTRIES - 1 - idx) * TLB_ENTRY_W +: TLB_ENTRY_W];
      if (cur[TLB_VALID_BIT] && (cur[TLB_VPN_LSB +: TLB_VPN_W] == va[31:12])) begin
        hit   = 1'b1;
        entry = cur;
      end
    end
  end

  assign pa    = {entry[TLB_PPN_LSB +: TLB_PPN_W], va[11:0]};
  assign fault = !hit || !entry[TLB_PRESENT_BIT] || (is_write && !entry[TLB_WRITABLE_BIT]);

  logic unused_pcd;
  assign unused_pcd = entry[TLB_PCD_BIT];

endmodule

// File: rtl/memsys_port_arbiter.sv
// Four-port memory arbiter over one byte array, one transaction at a time.
// Define MEMSYS_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module memsys_port_arbiter
  import memsys_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_valid,
  output logic             imem_ready,
  input  logic [31:0]      imem_address,
  input  logic             imem_wr_en,
  input  logic [127:0]     imem_wr_data,
  input  logic [7:0]       imem_wr_size,
  output logic             imem_dp_valid,
  input  logic             imem_dp_ready,
  output logic [127:0]     imem_dp_read_data,
  input  logic             rmem_valid,
  output logic             rmem_ready,
  input  logic [31:0]      rmem_address,
  input  logic             rmem_wr_en,
  input  logic [63:0]      rmem_wr_data,
  input  logic [7:0]       rmem_wr_size,
  output logic             rmem_dp_valid,
  input  logic             rmem_dp_ready,
  output logic [63:0]      rmem_dp_read_data,
  input  logic             wmem_valid,
  output logic             wmem_ready,
  input  logic [31:0]      wmem_address,
  input  logic             wmem_wr_en,
  input  logic [31:0]      wmem_wr_data,
  input  logic [7:0]       wmem_wr_size,
  output logic             wmem_dp_valid,
  input  logic             wmem_dp_ready,
  output logic [63:0]      wmem_dp_read_data,
  input  logic             emem_valid,
  output logic             emem_ready,
  input  logic [31:0]      emem_address,
  output logic             emem_dp_valid,
  input  logic             emem_dp_ready,
  output logic [31:0]      emem_dp_read_data,
  input  logic [TLB_W-1:0] tlb_contents,
  output logic             mem_fault
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  logic [7:0] mem [MEM_BYTES];

  state_e         state, state_next;
  port_e          grant, owner;
  logic           grant_vld, accept, access_done, owner_dp_ready;
  logic [3:0]     req;
  logic [CW-1:0]  cnt;
  logic [31:0]    va, tlb_pa, pa_q, wdata_q;
  logic [7:0]     wsize_q;
  logic           tlb_fault, fault_q, wr_q, resp_fault;
  logic [127:0]   rd_data, resp_data;

  assign req = {imem_valid, rmem_valid, wmem_valid, emem_valid} & {4{~reset}};

`ifdef MEMSYS_ROUND_ROBIN_EN
  port_e      last;
  logic [1:0] cand;

  always_comb begin
    grant     = PORT_E;
    grant_vld = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant     = port_e'(cand);
      end
    end
  end

  // Starting from PORT_I makes the first search begin at emem.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last <= PORT_I;
    else if (accept) last <= grant;
  end
`else
  always_comb begin
    grant_vld = |req;
    if (req[0])      grant = PORT_E;
    else if (req[1]) grant = PORT_W;
    else if (req[2]) grant = PORT_R;
    else             grant = PORT_I;
  end
`endif

  always_comb begin
    case (grant)
      PORT_E:  va = emem_address;
      PORT_W:  va = wmem_address;
      PORT_R:  va = rmem_address;
      default: va = imem_address;
    endcase
  end

  memsys_tlb_lookup u_tlb (
    .tlb_contents (tlb_contents),
    .va           (va),
    .is_write     (grant == PORT_W),
    .pa           (tlb_pa),
    .fault        (tlb_fault)
  );

  always_comb begin
    case (owner)
      PORT_E:  owner_dp_ready = emem_dp_ready;
      PORT_W:  owner_dp_ready = wmem_dp_ready;
      PORT_R:  owner_dp_ready = rmem_dp_ready;
      default: owner_dp_ready = imem_dp_ready;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    access_done = 1'b0;
    imem_ready  = 1'b0;
    rmem_ready  = 1'b0;
    wmem_ready  = 1'b0;
    emem_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          accept     = 1'b1;
          state_next = ST_ACCESS;
          case (grant)
            PORT_E:  emem_ready = 1'b1;
            PORT_W:  wmem_ready = 1'b1;
            PORT_R:  rmem_ready = 1'b1;
            default: imem_ready = 1'b1;
          endcase
        end
      end
      ST_ACCESS: begin
        if (fault_q || (cnt == CW'(MEM_LAT - 1))) begin
          access_done = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_dp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= PORT_E;
      cnt        <= '0;
      pa_q       <= '0;
      wdata_q    <= '0;
      wsize_q    <= '0;
      wr_q       <= 1'b0;
      fault_q    <= 1'b0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
    end else begin
      if (accept) begin
        owner   <= grant;
        cnt     <= '0;
        wdata_q <= wmem_wr_data;
        wsize_q <= wmem_wr_size;
        wr_q    <= (grant == PORT_W) && wmem_wr_en;
        // emem is physical; a write with wr_en=0 is acknowledged without touching memory.
        if (grant == PORT_E) begin
          pa_q    <= emem_address;
          fault_q <= 1'b0;
        end else if ((grant == PORT_W) && !wmem_wr_en) begin
          pa_q    <= tlb_pa;
          fault_q <= 1'b0;
        end else begin
          pa_q    <= tlb_pa;
          fault_q <= tlb_fault;
        end
      end else if (state == ST_ACCESS) begin
        cnt <= cnt + CW'(1);
      end
      if (access_done) begin
        resp_fault <= fault_q;
        resp_data  <= (fault_q || wr_q) ? '0 : rd_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < 16; k++) rd_data[8*k +: 8] = mem[AW'(pa_q + k)];
  end

  always_ff @(posedge clk) begin
    if (access_done && wr_q && !fault_q) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k < 32'(wsize_q)) mem[AW'(pa_q + k)] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign imem_dp_valid     = (state == ST_RESP) && (owner == PORT_I);
  assign rmem_dp_valid     = (state == ST_RESP) && (owner == PORT_R);
  assign wmem_dp_valid     = (state == ST_RESP) && (owner == PORT_W);
  assign emem_dp_valid     = (state == ST_RESP) && (owner == PORT_E);
  assign imem_dp_read_data = imem_dp_valid ? resp_data : '0;
  assign rmem_dp_read_data = rmem_dp_valid ? resp_data[63:0] : '0;
  assign emem_dp_read_data = emem_dp_valid ? resp_data[31:0] : '0;
  assign wmem_dp_read_data = '0;
  assign mem_fault         = (state == ST_RESP) && resp_fault;

  logic unused_inputs;
  assign unused_inputs = ^{imem_wr_en, imem_wr_data, imem_wr_size,
                           rmem_wr_en, rmem_wr_data, rmem_wr_size};

endmodule

// File: tb/tb_memsys_port_arbiter.sv
// Directed self-checking bench for memsys_port_arbiter (default fixed-priority build).
module tb_memsys_port_arbiter;
  import memsys_pkg::*;

  localparam int MEM_LAT = 2;
  localparam int P_E = 0, P_W = 1, P_R = 2, P_I = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_valid = 0, imem_ready, imem_wr_en = 0, imem_dp_valid, imem_dp_ready = 0;
  logic [31:0] imem_address = '0;
  logic [127:0] imem_wr_data = '0, imem_dp_read_data;
  logic [7:0] imem_wr_size = '0;
  logic rmem_valid = 0, rmem_ready, rmem_wr_en = 0, rmem_dp_valid, rmem_dp_ready = 0;
  logic [31:0] rmem_address = '0;
  logic [63:0] rmem_wr_data = '0, rmem_dp_read_data;
  logic [7:0] rmem_wr_size = '0;
  logic wmem_valid = 0, wmem_ready, wmem_wr_en = 0, wmem_dp_valid, wmem_dp_ready = 0;
  logic [31:0] wmem_address = '0, wmem_wr_data = '0;
  logic [7:0] wmem_wr_size = '0;
  logic [63:0] wmem_dp_read_data;
  logic emem_valid = 0, emem_ready, emem_dp_valid, emem_dp_ready = 0;
  logic [31:0] emem_address = '0, emem_dp_read_data;
  logic [TLB_W-1:0] tlb_contents = '0;
  logic mem_fault;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  memsys_port_arbiter #(.MEM_BYTES(65536), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_address(imem_address),
    .imem_wr_en(imem_wr_en), .imem_wr_data(imem_wr_data), .imem_wr_size(imem_wr_size),
    .imem_dp_valid(imem_dp_valid), .imem_dp_ready(imem_dp_ready), .imem_dp_read_data(imem_dp_read_data),
    .rmem_valid(rmem_valid), .rmem_ready(rmem_ready), .rmem_address(rmem_address),
    .rmem_wr_en(rmem_wr_en), .rmem_wr_data(rmem_wr_data), .rmem_wr_size(rmem_wr_size),
    .rmem_dp_valid(rmem_dp_valid), .rmem_dp_ready(rmem_dp_ready), .rmem_dp_read_data(rmem_dp_read_data),
    .wmem_valid(wmem_valid), .wmem_ready(wmem_ready), .wmem_address(wmem_address),
    .wmem_wr_en(wmem_wr_en), .wmem_wr_data(wmem_wr_data), .wmem_wr_size(wmem_wr_size),
    .wmem_dp_valid(wmem_dp_valid), .wmem_dp_ready(wmem_dp_ready), .wmem_dp_read_data(wmem_dp_read_data),
    .emem_valid(emem_valid), .emem_ready(emem_ready), .emem_address(emem_address),
    .emem_dp_valid(emem_dp_valid), .emem_dp_ready(emem_dp_ready), .emem_dp_read_data(emem_dp_read_data),
    .tlb_contents(tlb_contents), .mem_fault(mem_fault)
  );

  function automatic logic [7:0] pat(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ 8'hA5;
  endfunction

  task automatic set_entry(input int i, input logic [19:0] vpn, input logic [19:0] ppn,
                           input logic v, input logic p, input logic w);
    tlb_contents[(7 - i) * 44 +: 44] = {vpn, ppn, v, p, w, 1'b0};
  endtask

  task automatic set_valid(input int p, input logic v, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [7:0] ws);
    case (p)
      P_E: begin emem_valid = v; emem_address = addr; end
      P_W: begin wmem_valid = v; wmem_address = addr; wmem_wr_en = v; wmem_wr_data = wd; wmem_wr_size = ws; end
      P_R: begin rmem_valid = v; rmem_address = addr; end
      default: begin imem_valid = v; imem_address = addr; end
    endcase
  endtask

  task automatic set_dp_ready(input int p, input logic r);
    case (p)
      P_E: emem_dp_ready = r;
      P_W: wmem_dp_ready = r;
      P_R: rmem_dp_ready = r;
      default: imem_dp_ready = r;
    endcase
  endtask

  function automatic logic port_ready(input int p);
    case (p)
      P_E: return emem_ready;
      P_W: return wmem_ready;
      P_R: return rmem_ready;
      default: return imem_ready;
    endcase
  endfunction

  function automatic logic port_dp_valid(input int p);
    case (p)
      P_E: return emem_dp_valid;
      P_W: return wmem_dp_valid;
      P_R: return rmem_dp_valid;
      default: return imem_dp_valid;
    endcase
  endfunction

  function automatic logic [127:0] port_data(input int p);
    case (p)
      P_E: return {96'd0, emem_dp_read_data};
      P_W: return {64'd0, wmem_dp_read_data};
      P_R: return {64'd0, rmem_dp_read_data};
      default: return imem_dp_read_data;
    endcase
  endfunction

  // Drives one transaction and returns response data, fault and the accept-to-dp_valid latency.
  task automatic do_txn(input int p, input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] ws,
                        output logic [127:0] data, output logic flt, output int lat, output bit ok);
    bit seen;
    ok = 1; data = '0; flt = 0; lat = 0;
    @(posedge clk); #1;
    set_valid(p, 1'b1, addr, wd, ws);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = port_ready(p); end
    if (!seen) ok = 0;
    @(posedge clk); #1;
    set_valid(p, 1'b0, '0, '0, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); lat++; seen = port_dp_valid(p); end
    if (!seen) ok = 0;
    data = port_data(p);
    flt = mem_fault;
    set_dp_ready(p, 1'b1);
    @(posedge clk); #1;
    set_dp_ready(p, 1'b0);
  endtask

  task automatic test_reset;
    rmem_valid = 1; rmem_address = 32'h0200_0010;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({emem_ready, wmem_ready, rmem_ready, imem_ready} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0000", {emem_ready, wmem_ready, rmem_ready, imem_ready});
    end
    n_checks++;
    if ({emem_dp_valid, wmem_dp_valid, rmem_dp_valid, imem_dp_valid, mem_fault} !== 5'b0) begin
      n_fail++; $display("FAIL reset_dp_valid: got %b expected 00000", {emem_dp_valid, wmem_dp_valid, rmem_dp_valid, imem_dp_valid, mem_fault});
    end
    n_checks++;
    if ({imem_dp_read_data, rmem_dp_read_data, emem_dp_read_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got nonzero read data, expected 0");
    end
    @(posedge clk); #1;
    rmem_valid = 0;
    reset = 0;
  endtask

  task automatic test_rmem_read;
    logic [127:0] d; logic f; int lat; bit ok;
    do_txn(P_R, 32'h0200_0010, '0, '0, d, f, lat, ok);
    n_checks++;
    if (!ok || d[63:0] !== 64'h0807_0605_0403_0201) begin
      n_fail++; $display("FAIL rmem_data: got %h (ok=%0d) expected 0807060504030201", d[63:0], ok);
    end
    n_checks++;
    if (f !== 1'b0) begin n_fail++; $display("FAIL rmem_fault: got %b expected 0", f); end
    n_checks++;
    if (lat !== MEM_LAT + 1) begin n_fail++; $display("FAIL rmem_latency: got %0d expected %0d", lat, MEM_LAT + 1); end
    do_txn(P_R, 32'h0300_0008, '0, '0, d, f, lat, ok);
    n_checks++;
    if (!ok || f !== 1'b1 || d[63:0] !== 64'd0) begin
      n_fail++; $display("FAIL rmem_not_present: got fault=%b data=%h expected fault=1 data=0", f, d[63:0]);
    end
  endtask

  task automatic test_wmem;
    logic [127:0] d; logic f; int lat; bit ok;
    do_txn(P_W, 32'h0000_0100, 32'hAABB_CCDD, 8'd4, d, f, lat, ok);
    n_checks++;
    if (!ok || f !== 1'b1) begin n_fail++; $display("FAIL wmem_ro_fault: got %b (ok=%0d) expected 1", f, ok); end
    n_checks++;
    if (dut.mem[16'h0100] !== pat(32'h100) || dut.mem[16'h0103] !== pat(32'h103)) begin
      n_fail++; $display("FAIL wmem_ro_mem: got %h %h expected %h %h", dut.mem[16'h0100], dut.mem[16'h0103], pat(32'h100), pat(32'h103));
    end
    do_txn(P_W, 32'h0200_0020, 32'hAABB_CCDD, 8'd4, d, f, lat, ok);
    n_checks++;
    if (!ok || f !== 1'b0 || d !== '0) begin n_fail++; $display("FAIL wmem_ack: got fault=%b data=%h expected 0 0", f, d); end
    n_checks++;
    if ({dut.mem[16'h2023], dut.mem[16'h2022], dut.mem[16'h2021], dut.mem[16'h2020]} !== 32'hAABB_CCDD ||
        dut.mem[16'h2024] !== pat(32'h2024)) begin
      n_fail++; $display("FAIL wmem_bytes: got %h%h%h%h next %h expected aabbccdd next %h",
                         dut.mem[16'h2023], dut.mem[16'h2022], dut.mem[16'h2021], dut.mem[16'h2020], dut.mem[16'h2024], pat(32'h2024));
    end
    do_txn(P_W, 32'h0200_0028, 32'hAABB_CCDD, 8'd2, d, f, lat, ok);
    n_checks++;
    if ({dut.mem[16'h202A], dut.mem[16'h2029], dut.mem[16'h2028]} !== {pat(32'h202A), 16'hCCDD}) begin
      n_fail++; $display("FAIL wmem_size2: got %h%h%h expected %hccdd", dut.mem[16'h202A], dut.mem[16'h2029], dut.mem[16'h2028], pat(32'h202A));
    end
  endtask

  task automatic test_imem;
    logic [127:0] d, exp; logic f; int lat; bit ok;
    for (int k = 0; k < 16; k++) exp[8*k +: 8] = pat(32'h4000 + k);
    do_txn(P_I, 32'h0B00_0000, '0, '0, d, f, lat, ok);
    n_checks++;
    if (!ok || f !== 1'b0 || d !== exp) begin n_fail++; $display("FAIL imem_data: got %h f=%b expected %h f=0", d, f, exp); end
    do_txn(P_I, 32'h0F00_0000, '0, '0, d, f, lat, ok);
    n_checks++;
    if (!ok || f !== 1'b1 || d !== '0) begin n_fail++; $display("FAIL imem_miss: got fault=%b data=%h expected 1 0", f, d); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL fault_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_priority;
    int order[4]; int gcyc[4]; int n, cyc, idx; bit multi, done; logic [3:0] rdy; logic [31:0] edata;
    n = 0; cyc = 0; multi = 0; done = 0; edata = '0;
    @(posedge clk); #1;
    set_valid(P_E, 1, 32'h0000_0040, '0, '0);
    set_valid(P_W, 1, 32'h0200_0030, 32'h1234_5678, 8'd4);
    set_valid(P_R, 1, 32'h0200_0010, '0, '0);
    set_valid(P_I, 1, 32'h0B00_0000, '0, '0);
    emem_dp_ready = 1; wmem_dp_ready = 1; rmem_dp_ready = 1; imem_dp_ready = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); cyc++;
      rdy = {imem_ready, rmem_ready, wmem_ready, emem_ready};
      if ($countones(rdy) > 1) multi = 1;
      if (emem_dp_valid) edata = emem_dp_read_data;
      if (n == 4 && imem_dp_valid) done = 1;
      if (rdy != 4'b0 && n < 4) begin
        idx = rdy[0] ? P_E : rdy[1] ? P_W : rdy[2] ? P_R : P_I;
        order[n] = idx; gcyc[n] = cyc; n++;
        @(posedge clk); #1;
        set_valid(idx, 0, '0, '0, '0);
      end
    end
    @(posedge clk); #1;
    emem_dp_ready = 0; wmem_dp_ready = 0; rmem_dp_ready = 0; imem_dp_ready = 0;
    n_checks++;
    if (n != 4 || !done) begin n_fail++; $display("FAIL prio_complete: got %0d grants done=%0d expected 4 1", n, done); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (order[k] != k) begin n_fail++; $display("FAIL prio_order%0d: got port %0d expected %0d", k, order[k], k); end
      end
      n_checks++;
      if (gcyc[1] - gcyc[0] != MEM_LAT + 2) begin
        n_fail++; $display("FAIL grant_gap: got %0d expected %0d", gcyc[1] - gcyc[0], MEM_LAT + 2);
      end
    end
    n_checks++;
    if (multi) begin n_fail++; $display("FAIL ready_onehot: got multiple readies expected one"); end
    n_checks++;
    if (edata !== {pat(32'h43), pat(32'h42), pat(32'h41), pat(32'h40)}) begin
      n_fail++; $display("FAIL emem_data: got %h expected %h", edata, {pat(32'h43), pat(32'h42), pat(32'h41), pat(32'h40)});
    end
  endtask

  task automatic test_hold_resp;
    bit seen;
    @(posedge clk); #1;
    set_valid(P_R, 1, 32'h0200_0010, '0, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = rmem_ready; end
    @(posedge clk); #1;
    set_valid(P_R, 0, '0, '0, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = rmem_dp_valid; end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL hold_start: got no rmem_dp_valid expected 1"); end
    set_valid(P_I, 1, 32'h0B00_0000, '0, '0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rmem_dp_valid !== 1'b1 || rmem_dp_read_data !== 64'h0807_0605_0403_0201 || imem_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: got v=%b d=%h irdy=%b expected 1 0807060504030201 0",
                           i, rmem_dp_valid, rmem_dp_read_data, imem_ready);
      end
      @(negedge clk);
    end
    rmem_dp_ready = 1;
    @(posedge clk); #1;
    rmem_dp_ready = 0;
    @(negedge clk);
    n_checks++;
    if (imem_ready !== 1'b1 || rmem_dp_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got irdy=%b rv=%b expected 1 0", imem_ready, rmem_dp_valid);
    end
    @(posedge clk); #1;
    set_valid(P_I, 0, '0, '0, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = imem_dp_valid; end
    imem_dp_ready = 1;
    @(posedge clk); #1;
    imem_dp_ready = 0;
  endtask

  task automatic test_reset_mid_write;
    bit seen, ack; logic [127:0] d; logic f; int lat; bit ok;
    @(posedge clk); #1;
    set_valid(P_W, 1, 32'h0200_0040, 32'h1122_3344, 8'd4);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = wmem_ready; end
    @(posedge clk); #1;
    set_valid(P_W, 0, '0, '0, '0);
    reset = 1;
    @(negedge clk);
    n_checks++;
    if ({emem_ready, wmem_ready, rmem_ready, imem_ready, emem_dp_valid, wmem_dp_valid,
         rmem_dp_valid, imem_dp_valid, mem_fault} !== 9'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got nonzero handshake/fault outputs expected 0");
    end
    @(posedge clk); #1;
    reset = 0;
    ack = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (wmem_dp_valid) ack = 1; end
    n_checks++;
    if (ack) begin n_fail++; $display("FAIL reset_mid_ack: got wmem_dp_valid=1 expected 0"); end
    n_checks++;
    if ({dut.mem[16'h2043], dut.mem[16'h2042], dut.mem[16'h2041], dut.mem[16'h2040]} !==
        {pat(32'h2043), pat(32'h2042), pat(32'h2041), pat(32'h2040)}) begin
      n_fail++; $display("FAIL reset_mid_mem: got %h%h%h%h expected %h%h%h%h",
                         dut.mem[16'h2043], dut.mem[16'h2042], dut.mem[16'h2041], dut.mem[16'h2040],
                         pat(32'h2043), pat(32'h2042), pat(32'h2041), pat(32'h2040));
    end
    do_txn(P_R, 32'h0200_0010, '0, '0, d, f, lat, ok);
    n_checks++;
    if (!ok || d[63:0] !== 64'h0807_0605_0403_0201) begin
      n_fail++; $display("FAIL reset_recover: got %h (ok=%0d) expected 0807060504030201", d[63:0], ok);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) dut.mem[a] = pat(a);
    for (int k = 0; k < 8; k++) dut.mem[16'h2010 + k] = 8'(k + 1);
    set_entry(0, 20'h00000, 20'h00000, 1, 1, 0);
    set_entry(1, 20'h02000, 20'h00002, 1, 1, 1);
    set_entry(2, 20'h03000, 20'h00003, 1, 0, 1);
    set_entry(3, 20'h0B000, 20'h00004, 1, 1, 1);
    set_entry(5, 20'h02000, 20'h00007, 1, 1, 1);
    test_reset();
    test_rmem_read();
    test_wmem();
    test_imem();
    test_priority();
    test_hold_resp();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
